// File: rtl/store_activation_pkg.sv
// Constants shared between the activation store and loader: lane geometry,
// FSM encodings and the ReLU clamp applied to output bytes.
package store_activation_pkg;

    localparam int BRAM_WIDTH   = 32;
    localparam int WEIGHT_WIDTH = 8;
    localparam int BRAM_BYTE    = BRAM_WIDTH / WEIGHT_WIDTH;
    localparam int LANE_W       = $clog2(BRAM_BYTE);
    localparam int COUNT_W      = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic logic [WEIGHT_WIDTH-1:0] relu_clamp(
        input logic [WEIGHT_WIDTH-1:0] value,
        input logic                    enable
    );
        if (enable && value[WEIGHT_WIDTH-1]) begin
            relu_clamp = {WEIGHT_WIDTH{1'b0}};
        end else begin
            relu_clamp = value;
        end
    endfunction

endpackage

// File: rtl/act_word_packer.sv
// Collects activation bytes into a little-endian word with a lane mask and
// presents the merged word/mask in the cycle that completes it.
module act_word_packer
    import store_activation_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    relu_en,
    input  logic [WEIGHT_WIDTH-1:0] byte_in,
    input  logic [LANE_W-1:0]       lane,
    input  logic                    push,
    input  logic                    last,
    output logic [BRAM_WIDTH-1:0]   word,
    output logic [BRAM_BYTE-1:0]    wen,
    output logic                    word_done
);

    logic [BRAM_WIDTH-1:0]   lane_buf_r;
    logic [BRAM_BYTE-1:0]    mask_r;
    logic [WEIGHT_WIDTH-1:0] stored_s;

    assign stored_s  = relu_clamp(byte_in, relu_en);
    assign word_done = push && ((lane == LANE_W'(BRAM_BYTE - 1)) || last);

    // Merge the incoming byte into its lane on top of the held partial word.
    always_comb begin
        word = lane_buf_r;
        wen  = mask_r;
        for (int k = 0; k < BRAM_BYTE; k++) begin
            if (push && (lane == LANE_W'(k))) begin
                word[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] = stored_s;
                wen[k]                               = 1'b1;
            end else begin
                word[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] = lane_buf_r[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                wen[k]                               = mask_r[k];
            end
        end
    end

    // Partial word storage; emptied when a word leaves or a new store begins.
    always_ff @(posedge clk) begin
        if (rst || clear || word_done) begin
            lane_buf_r <= {BRAM_WIDTH{1'b0}};
            mask_r     <= {BRAM_BYTE{1'b0}};
        end else if (push) begin
            lane_buf_r <= word;
            mask_r     <= wen;
        end else begin
            lane_buf_r <= lane_buf_r;
            mask_r     <= mask_r;
        end
    end

endmodule

// File: rtl/store_activation.sv
// Activation write-back engine: streams bytes from the PE output stage into
// the activation BRAM as byte-enabled 32-bit writes.
module store_activation
    import store_activation_pkg::*;
#(
    parameter int BRAM_ADDR_BIT = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     store_start,
    input  logic [BRAM_ADDR_BIT-1:0] base_addr,
    input  logic [COUNT_W-1:0]       count,
    input  logic                     relu_en,
    input  logic [WEIGHT_WIDTH-1:0]  data_in,
    input  logic                     data_valid,
    output logic                     data_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     BRAM_clk,
    output logic                     BRAM_en,
    output logic                     BRAM_rst,
    output logic [BRAM_ADDR_BIT-1:0] BRAM_addr,
    output logic [BRAM_WIDTH-1:0]    BRAM_din,
    output logic [BRAM_BYTE-1:0]     BRAM_wen
);

    state_t                   state_r, state_s;
    logic [BRAM_ADDR_BIT-1:0] cur_addr_r;
    logic [COUNT_W-1:0]       remaining_r;
    logic                     done_r;
    logic [BRAM_ADDR_BIT-1:0] addr_r;
    logic [BRAM_WIDTH-1:0]    din_r;
    logic [BRAM_BYTE-1:0]     wen_r;
    logic                     accept_s, handshake_s, last_s, word_done_s;
    logic [BRAM_WIDTH-1:0]    word_s;
    logic [BRAM_BYTE-1:0]     word_wen_s;

    assign accept_s    = (state_r == IDLE) && store_start;
    assign handshake_s = (state_r == PACK) && data_valid;
    assign last_s      = (remaining_r == COUNT_W'(1));

    act_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept_s),
        .relu_en   (relu_en),
        .byte_in   (data_in),
        .lane      (cur_addr_r[LANE_W-1:0]),
        .push      (handshake_s),
        .last      (last_s),
        .word      (word_s),
        .wen       (word_wen_s),
        .word_done (word_done_s)
    );

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (store_start) begin
                    if (count == {COUNT_W{1'b0}}) begin
                        state_s = FLUSH;
                    end else begin
                        state_s = PACK;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            PACK: begin
                if (handshake_s && last_s) begin
                    state_s = FLUSH;
                end else begin
                    state_s = PACK;
                end
            end
            FLUSH:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Address/byte counters, done flag and BRAM write-port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr_r  <= {BRAM_ADDR_BIT{1'b0}};
            remaining_r <= {COUNT_W{1'b0}};
            done_r      <= 1'b0;
            addr_r      <= {BRAM_ADDR_BIT{1'b0}};
            din_r       <= {BRAM_WIDTH{1'b0}};
            wen_r       <= {BRAM_BYTE{1'b0}};
        end else begin
            if (accept_s) begin
                cur_addr_r  <= base_addr;
                remaining_r <= count;
            end else if (handshake_s) begin
                cur_addr_r  <= cur_addr_r + BRAM_ADDR_BIT'(1);
                remaining_r <= remaining_r - COUNT_W'(1);
            end else begin
                cur_addr_r  <= cur_addr_r;
                remaining_r <= remaining_r;
            end

            if (accept_s) begin
                done_r <= 1'b0;
            end else if (state_r == FLUSH) begin
                done_r <= 1'b1;
            end else begin
                done_r <= done_r;
            end

            // Address and data hold between writes; only the enables drop.
            if (word_done_s) begin
                addr_r <= {cur_addr_r[BRAM_ADDR_BIT-1:LANE_W], {LANE_W{1'b0}}};
                din_r  <= word_s;
                wen_r  <= word_wen_s;
            end else begin
                addr_r <= addr_r;
                din_r  <= din_r;
                wen_r  <= {BRAM_BYTE{1'b0}};
            end
        end
    end

    assign data_ready = (state_r == PACK);
    assign busy       = (state_r != IDLE);
    assign done       = done_r;
    assign BRAM_clk   = clk;
    assign BRAM_en    = 1'b1;
    assign BRAM_rst   = 1'b0;
    assign BRAM_addr  = addr_r;
    assign BRAM_din   = din_r;
    assign BRAM_wen   = wen_r;

endmodule

// File: tb/tb_store_activation.sv
// Directed bench for store_activation: hand-computed BRAM writes and
// handshake/done timing checked with immediate assertions.
module tb_store_activation;

    logic        clk;
    logic        rst;
    logic        store_start;
    logic [31:0] base_addr;
    logic [23:0] count;
    logic        relu_en;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready, busy, done;
    logic        BRAM_clk, BRAM_en, BRAM_rst;
    logic [31:0] BRAM_addr, BRAM_din;
    logic [3:0]  BRAM_wen;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int wr_mark;

    store_activation dut (
        .clk         (clk),
        .rst         (rst),
        .store_start (store_start),
        .base_addr   (base_addr),
        .count       (count),
        .relu_en     (relu_en),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .busy        (busy),
        .done        (done),
        .BRAM_clk    (BRAM_clk),
        .BRAM_en     (BRAM_en),
        .BRAM_rst    (BRAM_rst),
        .BRAM_addr   (BRAM_addr),
        .BRAM_din    (BRAM_din),
        .BRAM_wen    (BRAM_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle the BRAM sees a write enable.
    always @(negedge clk) begin
        if (!rst && BRAM_wen != 4'h0) wr_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] base, input logic [23:0] n, input logic relu);
        store_start = 1'b1;
        base_addr   = base;
        count       = n;
        relu_en     = relu;
        step();
        store_start = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        data_valid = 1'b1;
        data_in    = d;
        step();
        data_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; store_start = 1'b0; base_addr = 32'h0; count = 24'h0;
        relu_en = 1'b0; data_in = 8'h00; data_valid = 1'b0;
        step(); step();
        check("rst_ready", {31'h0, data_ready}, 32'h0);
        check("rst_busy",  {31'h0, busy}, 32'h0);
        check("rst_done",  {31'h0, done}, 32'h0);
        check("rst_wen",   {28'h0, BRAM_wen}, 32'h0);
        check("rst_addr",  BRAM_addr, 32'h0);
        check("rst_din",   BRAM_din, 32'h0);
        check("bram_en",   {29'h0, BRAM_en, BRAM_rst, 1'b0}, 32'h4);
        rst = 1'b0;
        step();

        // Aligned store of 8 bytes.
        start(32'h100, 24'd8, 1'b0);
        check("a_ready", {31'h0, data_ready}, 32'h1);
        check("a_busy",  {31'h0, busy}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            push(8'(i + 1));
            if (i == 0) check("a_nowen", {28'h0, BRAM_wen}, 32'h0);
            if (i == 3) begin
                check("a_w0_addr", BRAM_addr, 32'h100);
                check("a_w0_din",  BRAM_din, 32'h04030201);
                check("a_w0_wen",  {28'h0, BRAM_wen}, 32'hF);
            end
        end
        check("a_w1_addr", BRAM_addr, 32'h104);
        check("a_w1_din",  BRAM_din, 32'h08070605);
        check("a_w1_wen",  {28'h0, BRAM_wen}, 32'hF);
        check("a_flush_done", {31'h0, done}, 32'h0);
        check("a_flush_busy", {31'h0, busy}, 32'h1);
        step();
        check("a_done", {31'h0, done}, 32'h1);
        check("a_idle", {31'h0, busy}, 32'h0);
        check("a_wen0", {28'h0, BRAM_wen}, 32'h0);
        check("a_hold_addr", BRAM_addr, 32'h104);

        // Unaligned head and tail.
        start(32'h202, 24'd5, 1'b0);
        check("u_done_clr", {31'h0, done}, 32'h0);
        push(8'hA0);
        check("u_nowen", {28'h0, BRAM_wen}, 32'h0);
        push(8'hA1);
        check("u_h_addr", BRAM_addr, 32'h200);
        check("u_h_wen",  {28'h0, BRAM_wen}, 32'hC);
        check("u_h_din",  {16'h0, BRAM_din[31:16]}, 32'hA1A0);
        push(8'hA2);
        push(8'hA3);
        push(8'hA4);
        check("u_t_addr", BRAM_addr, 32'h204);
        check("u_t_wen",  {28'h0, BRAM_wen}, 32'h7);
        check("u_t_din",  {8'h0, BRAM_din[23:0]}, 32'hA4A3A2);
        step();
        check("u_done", {31'h0, done}, 32'h1);

        // ReLU clamp.
        start(32'h0, 24'd4, 1'b1);
        push(8'h80); push(8'h7F); push(8'hFF); push(8'h00);
        check("r_addr", BRAM_addr, 32'h0);
        check("r_din",  BRAM_din, 32'h00007F00);
        check("r_wen",  {28'h0, BRAM_wen}, 32'hF);
        step();

        // Valid gaps: 1,0,0,1,1,0,1.
        start(32'h300, 24'd4, 1'b0);
        wr_mark = wr_cnt;
        push(8'h11); step(); step();
        push(8'h22); push(8'h33); step();
        check("g_nowen", {28'h0, BRAM_wen}, 32'h0);
        check("g_ready", {31'h0, data_ready}, 32'h1);
        push(8'h44);
        check("g_addr", BRAM_addr, 32'h300);
        check("g_din",  BRAM_din, 32'h44332211);
        check("g_wen",  {28'h0, BRAM_wen}, 32'hF);
        step(); step();
        check("g_writes", wr_cnt - wr_mark, 32'd1);

        // Zero-length store, twice.
        wr_mark = wr_cnt;
        start(32'h500, 24'd0, 1'b0);
        check("z_done_t1", {31'h0, done}, 32'h0);
        check("z_busy_t1", {31'h0, busy}, 32'h1);
        step();
        check("z_done_t2", {31'h0, done}, 32'h1);
        check("z_busy_t2", {31'h0, busy}, 32'h0);
        start(32'h500, 24'd0, 1'b0);
        check("z2_done_clr", {31'h0, done}, 32'h0);
        step();
        check("z2_done", {31'h0, done}, 32'h1);
        step();
        check("z_writes", wr_cnt - wr_mark, 32'd0);

        // Reset after 2 of 4 bytes, then a clean run.
        wr_mark = wr_cnt;
        start(32'h400, 24'd4, 1'b0);
        push(8'hDE); push(8'hAD);
        rst = 1'b1;
        step();
        check("m_done",  {31'h0, done}, 32'h0);
        check("m_busy",  {31'h0, busy}, 32'h0);
        check("m_wen",   {28'h0, BRAM_wen}, 32'h0);
        check("m_ready", {31'h0, data_ready}, 32'h0);
        rst = 1'b0;
        step(); step();
        check("m_writes", wr_cnt - wr_mark, 32'd0);
        start(32'h400, 24'd4, 1'b0);
        push(8'h5A); push(8'h6B); push(8'h7C); push(8'h8D);
        check("m2_addr", BRAM_addr, 32'h400);
        check("m2_din",  BRAM_din, 32'h8D7C6B5A);
        check("m2_wen",  {28'h0, BRAM_wen}, 32'hF);
        step();
        check("m2_done", {31'h0, done}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_activation.md
# store_activation

Write-back engine for the convolution datapath: accepts a stream of 8-bit output activations and stores them to a byte-addressed 32-bit BRAM port. Bytes are packed into little-endian words and written with byte enables. Byte lane k of a word holds the byte at byte address word_addr+k, which is the layout the activation loader reads. It sits between the PE array's output stage and the activation BRAM, and its `done` lets the controller start the next layer's load.

## Interface
- BRAM_ADDR_BIT, 32, byte-address width of the BRAM port
- BRAM_WIDTH, 32, BRAM data width
- WEIGHT_WIDTH, 8, activation byte width
- BRAM_BYTE, BRAM_WIDTH/8 (=4), byte lanes per word
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- store_start  in  1  start pulse; sampled only in IDLE
- base_addr  in  BRAM_ADDR_BIT  byte address of the first output byte; may be unaligned
- count  in  24  number of bytes to store
- relu_en  in  1  clamp negative (signed) bytes to 0
- data_in  in  WEIGHT_WIDTH  activation byte
- data_valid  in  1  data_in valid
- data_ready  out  1  high in PACK only
- busy  out  1  high in any state other than IDLE
- done  out  1  set when the last write has been issued; held until the next accepted store_start
- BRAM_clk  out  1  equals clk
- BRAM_en  out  1  constant 1
- BRAM_rst  out  1  constant 0
- BRAM_addr  out  BRAM_ADDR_BIT  word-aligned byte address (bits [1:0] = 0)
- BRAM_din  out  BRAM_WIDTH  write data; lane k = din[8k+:8]
- BRAM_wen  out  BRAM_BYTE  per-lane write enable

## Operation
- States: IDLE, PACK, FLUSH.
- IDLE:
  - On store_start, latch base_addr into cur_addr and count into remaining, clear done, clear the lane buffer and lane mask.
  - count==0: go to FLUSH with no write.
  - Otherwise go to PACK.
  - store_start in any other state is ignored.
- PACK (one byte per cycle while data_valid):
  - On each handshake (data_valid && data_ready), lane = cur_addr[1:0].
  - The byte is written to buf[lane] and mask[lane] is set. The stored value is 0 if relu_en is set and data_in[7] is 1; otherwise it is data_in.
  - Then cur_addr += 1 and remaining -= 1.
- Write issue:
  - A write is issued on a handshake where lane==3 or remaining==1.
  - Output registers load BRAM_addr = {cur_addr[MSB:2],2'b00}.
  - BRAM_din is the buffer merged with the new byte. BRAM_wen is the mask merged with the new lane bit.
  - The buffer and mask are cleared in the same cycle.
  - In every other cycle, BRAM_wen = 0. BRAM_din and BRAM_addr hold their previous values.
- Exit from PACK: the handshake with remaining==1 moves the FSM to FLUSH.
- FLUSH (one cycle): set done=1, go to IDLE.
- Unaligned base: the first write carries only the upper lanes (base[1:0]=2 gives wen=4'b1100). The final word may be partial (low lanes only).
- Reset values: all state cleared; data_ready=0, busy=0, done=0, BRAM_wen=0, BRAM_addr=0, BRAM_din=0; FSM in IDLE.
- Reset mid-operation: the partial buffer is discarded and no further writes are issued. Outputs take their reset values at the next edge.

## Timing
- Throughput: 1 byte/cycle with no stalls, including across word boundaries.
- Write latency: a handshake in cycle T that completes a word drives BRAM_wen≠0 during T+1. The BRAM commits at the end of T+1.
- Done latency:
  - The last handshake at T gives state FLUSH and the final wen at T+1.
  - done is 1 and busy is 0 from T+2.
- count==0: store_start at T gives FLUSH at T+1 and done=1 at T+2; BRAM_wen stays 0.
- data_valid gaps in PACK: no write and no address change; the partial word is retained.

## Structure
- Shared package (with the loader's constants): BRAM_BYTE, the state encodings (IDLE=0, PACK=1, FLUSH=2), and the lane-index width.
- One sub-module, `act_word_packer`:
  - Holds the lane buffer and mask, and applies ReLU.
  - Inputs: byte, lane, push, last.
  - Outputs: word, wen, word_done.
- The top level holds the FSM, the address and remaining counters, and the output registers.

## Test plan
- Aligned store: base=0x100, count=8, relu_en=0, bytes 0x01..0x08 continuous.
  - Two writes: addr 0x100 din 0x04030201 wen 4'hF, then addr 0x104 din 0x08070605 wen 4'hF.
  - done rises 2 cycles after the 8th byte.
- Unaligned head and tail: base=0x202, count=5, bytes 0xA0..0xA4.
  - addr 0x200 wen 4'b1100 din[31:16]=0xA1A0.
  - addr 0x204 wen 4'b0111 din[23:0]=0xA4A3A2.
- ReLU: relu_en=1, base=0, count=4, bytes 0x80,0x7F,0xFF,0x00 → addr 0 din 0x00007F00 wen 4'hF.
- Backpressure-free gaps: count=4, data_valid toggling 1,0,0,1,1,0,1 → exactly one write, with contents identical to the continuous case; BRAM_wen=0 on all other cycles.
- count=0: no BRAM_wen pulses, done=1 two cycles after store_start. A second store_start in IDLE clears done for one cycle and then re-runs.
- Reset mid-operation: rst after 2 of 4 bytes → no write is issued, and done=0, busy=0, BRAM_wen=0 on the next edge. A subsequent full run writes the correct word.
